arb_req_client: RTL and testbench
=================================

// Module: arb_req_client
// PURPOSE
// - Requester-side agent for the non-absolute fixed-priority arbiter: one instance per arbiter req/grant pair.
// - Accepts a burst job, raises req and holds it until grant, then issues the burst beats on the shared bus.
// - Drops req after the last beat and waits for grant to fall before accepting the next job.
// - Follows the arbiter's hold-until-release rule: grant persists while req is held.
// PARAMETERS
// - LEN_W    4   job length field width; burst = job_len+1 beats (1..2**LEN_W)
// - TIMEOUT  64  cycles of waiting in REQ before the starve flag sets (>=2)
// - TO_W     $clog2(TIMEOUT+1)  wait-counter width; derived, do not override
// PORTS
// - clk          in   1      clock
// - rst_n        in   1      reset, asynchronous, active-low
// - job_valid    in   1      job offered
// - job_len      in   LEN_W  beats minus one
// - job_ready    out  1      job accepted when job_valid & job_ready
// - req          out  1      request to arbiter (registered)
// - grant        in   1      grant from arbiter (registered on arbiter side)
// - bus_valid    out  1      beat valid = (state==XFER) & grant
// - bus_ready    in   1      bus accepts beat
// - bus_last     out  1      final beat of burst (qualified by bus_valid)
// - beat_idx     out  LEN_W  index of current beat, 0-based
// - starve       out  1      sticky: waited >= TIMEOUT cycles in REQ
// - err_lost     out  1      1-cycle pulse: grant fell during XFER
// BEHAVIOUR
// - Reset (async, immediate): state=IDLE, req=0, beat counter=0, len register=0, wait counter=0, starve=0, err_lost=0.
//   Combinational outputs follow: job_ready=1, bus_valid=0. Reset mid-burst abandons the burst.
// - FSM states: IDLE, REQ, XFER, REL.
// - IDLE: job_ready=1. On accept: latch job_len; clear beat_cnt, wait_cnt and starve; go to REQ.
//   req=1 from the next cycle.
// - REQ: req=1, job_ready=0. wait_cnt increments and saturates at TIMEOUT.
//   When wait_cnt reaches TIMEOUT-1 while grant=0, starve is set on the next edge.
//   On grant=1, go to XFER; starve is kept.
// - XFER: req=1. bus_valid=grant. On bus_valid & bus_ready: beat_cnt++.
//   bus_last = (beat_cnt==len). A handshake on the last beat sets req=0 and moves to REL.
//   bus_ready=0 stalls the burst with req held; there is no timeout in XFER.
// - XFER with grant=0 (protocol violation): no beat is transferred that cycle.
//   Pulse err_lost, set req=0 and go to REL; the remaining beats are dropped.
// - REL: req=0, job_ready=0. Wait for grant=0, then go to IDLE.
//   This guarantees req is low for at least 1 cycle between bursts, so the arbiter re-arbitrates.
// - Grant seen in IDLE or REQ-entry cycle before req was registered high: ignored; no error.
// - Latency: accept@t -> req@t+1 -> arbiter grant@t+2 at best -> state XFER@t+3 -> first beat@t+3.
//   A 1-beat job with bus_ready=1: req drops @t+4, grant drops @t+5, IDLE @t+6.
// - beat_idx = beat_cnt. The counter is LEN_W wide and the last beat is index len, so it never wraps.
// - job_len is latched only on accept; later changes are ignored.
// STRUCTURE
// - Shared package arb_pkg:
//   - typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_REL} arb_cli_st_t.
//   - Default LEN_W and TIMEOUT localparams; REQ_NUM, shared with the arbiter.
// - One sub-module: arb_sat_timer (saturating wait counter with clear, enable and terminal flag), which drives starve.
// - Everything else stays in the top module.
// TESTING
// - Single job: job_len=3, grant arrives 1 cycle after req, bus_ready=1.
//   -> 4 beats with beat_idx 0..3; bus_last only on idx 3; req low the cycle after; IDLE after grant falls.
// - Back-to-back jobs: job_valid held with job_len=0.
//   -> job_ready=0 until REL sees grant=0; req has at least 1 low cycle between bursts.
// - Stall: job_len=2 with bus_ready low on beat 1 for 5 cycles.
//   -> req and bus_valid held; beat_idx stays 1; burst completes with 3 handshakes.
// - Starvation: grant held low 70 cycles, TIMEOUT=64.
//   -> starve=1 from cycle 64 of REQ; stays 1 through XFER; clears on next accept.
// - Grant loss: grant forced 0 at beat 1 of 4.
//   -> err_lost 1-cycle pulse; bus_valid=0 that cycle; req=0 next cycle; IDLE after grant stays 0.
// - Reset mid-XFER: rst_n low at beat 2.
//   -> req, bus_valid, starve go 0 immediately; IDLE with job_ready=1 after release.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared arbiter definitions: client FSM states and default sizing,
// used by the requester client and by the arbiter itself.
package arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_XFER, ST_REL} arb_cli_st_t;

  localparam int ARB_LEN_W   = 4;
  localparam int ARB_TIMEOUT = 64;
  localparam int REQ_NUM     = 4;

endpackage

// File: rtl/arb_req_client_if.sv
// Job, arbiter and bus handshake bundle for one requester client.
// The master modport is the client side; slave is the job source, arbiter and bus.
interface arb_req_client_if
  import arb_pkg::*;
#(
  parameter int LEN_W = ARB_LEN_W
) ();

  logic             job_valid;
  logic [LEN_W-1:0] job_len;
  logic             job_ready;
  logic             req;
  logic             grant;
  logic             bus_valid;
  logic             bus_ready;
  logic             bus_last;
  logic [LEN_W-1:0] beat_idx;

  modport master (
    input  job_valid, job_len, grant, bus_ready,
    output job_ready, req, bus_valid, bus_last, beat_idx
  );

  modport slave (
    output job_valid, job_len, grant, bus_ready,
    input  job_ready, req, bus_valid, bus_last, beat_idx
  );

endinterface

// File: rtl/arb_sat_timer.sv
// Saturating wait counter with clear and enable; the sticky terminal flag
// rises on the edge after the count has reached TIMEOUT-1 while enabled.
module arb_sat_timer #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic flag
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      flag <= 1'b0;
    end else if (en) begin
      if (cnt != TO_W'(TIMEOUT)) cnt <= cnt + 1'b1;
      if (cnt >= TO_W'(TIMEOUT - 1)) flag <= 1'b1;
    end
  end

endmodule

// File: rtl/arb_req_client.sv
// Requester-side agent for the fixed-priority arbiter: takes a burst job,
// holds req until grant, streams the beats, then releases and waits for grant to drop.
module arb_req_client
  import arb_pkg::*;
#(
  parameter int LEN_W   = ARB_LEN_W,
  parameter int TIMEOUT = ARB_TIMEOUT,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  arb_req_client_if.master cli,
  output logic             starve,
  output logic             err_lost
);

  arb_cli_st_t      state;
  logic             req_q;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] len_q;
  logic             accept;
  logic             on_last;

  assign accept        = (state == ST_IDLE) && cli.job_valid;
  assign on_last       = (beat_cnt == len_q);
  assign cli.job_ready = (state == ST_IDLE);
  assign cli.req       = req_q;
  assign cli.bus_valid = (state == ST_XFER) && cli.grant;
  assign cli.bus_last  = cli.bus_valid && on_last;
  assign cli.beat_idx  = beat_cnt;

  arb_sat_timer #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_wait_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   ((state == ST_REQ) && !cli.grant),
    .flag (starve)
  );

  // Losing grant mid-burst abandons the remaining beats rather than re-requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      req_q    <= 1'b0;
      beat_cnt <= '0;
      len_q    <= '0;
      err_lost <= 1'b0;
    end else begin
      err_lost <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            len_q    <= cli.job_len;
            beat_cnt <= '0;
            req_q    <= 1'b1;
            state    <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (cli.grant) state <= ST_XFER;
        end
        ST_XFER: begin
          if (!cli.grant) begin
            err_lost <= 1'b1;
            req_q    <= 1'b0;
            state    <= ST_REL;
          end else if (cli.bus_ready) begin
            if (on_last) begin
              req_q <= 1'b0;
              state <= ST_REL;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        ST_REL: begin
          if (!cli.grant) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arb_req_client.sv
// Directed bench for arb_req_client with a one-cycle registered arbiter model
// that can be held off (starvation) or forced low (grant loss).
module tb_arb_req_client;

  logic clk;
  logic rst_n;
  logic starve;
  logic err_lost;
  logic arb_en;
  logic grant_kill;
  logic arb_grant;
  int   hs_cnt;
  int   hs_base;
  int   n_checks;
  int   n_err;

  logic [12:1] exp_req;
  logic [12:1] exp_jr;
  logic [12:1] exp_bv;

  arb_req_client_if #(.LEN_W(4)) ifc ();

  arb_req_client #(
    .LEN_W  (4),
    .TIMEOUT(64)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .cli     (ifc.master),
    .starve  (starve),
    .err_lost(err_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) arb_grant <= 1'b0;
    else        arb_grant <= ifc.req & arb_en;
  end

  assign ifc.grant = arb_grant & ~grant_kill;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) hs_cnt <= 0;
    else if (ifc.bus_valid && ifc.bus_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    arb_en        = 1'b1;
    grant_kill    = 1'b0;
    ifc.job_valid = 1'b0;
    ifc.job_len   = 4'd0;
    ifc.bus_ready = 1'b1;
    exp_req       = 12'b000111000111;
    exp_jr        = 12'b100000100000;
    exp_bv        = 12'b000100000100;

    repeat (2) next_cycle();
    check_output("rst_job_ready", 32'(ifc.job_ready), 1);
    check_output("rst_req", 32'(ifc.req), 0);
    check_output("rst_bus_valid", 32'(ifc.bus_valid), 0);
    check_output("rst_beat_idx", 32'(ifc.beat_idx), 0);
    check_output("rst_starve", 32'(starve), 0);
    check_output("rst_err_lost", 32'(err_lost), 0);
    rst_n = 1'b1;
    next_cycle();

    $display("[TB] single 4-beat job");
    ifc.job_valid = 1'b1;
    ifc.job_len   = 4'd3;
    next_cycle();
    check_output("t1_req_up", 32'(ifc.req), 1);
    check_output("t1_jr_low", 32'(ifc.job_ready), 0);
    ifc.job_valid = 1'b0;
    ifc.job_len   = 4'd9;
    next_cycle();
    check_output("t1_no_beat_yet", 32'(ifc.bus_valid), 0);
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      check_output("t1_bus_valid", 32'(ifc.bus_valid), 1);
      check_output("t1_beat_idx", 32'(ifc.beat_idx), i);
      check_output("t1_bus_last", 32'(ifc.bus_last), (i == 3) ? 1 : 0);
      next_cycle();
    end
    check_output("t1_req_drop", 32'(ifc.req), 0);
    check_output("t1_bv_drop", 32'(ifc.bus_valid), 0);
    next_cycle();
    check_output("t1_rel_wait", 32'(ifc.job_ready), 0);
    next_cycle();
    check_output("t1_idle", 32'(ifc.job_ready), 1);

    $display("[TB] back-to-back single-beat jobs");
    ifc.job_valid = 1'b1;
    ifc.job_len   = 4'd0;
    for (int k = 1; k <= 12; k++) begin
      next_cycle();
      check_output("t2_req", 32'(ifc.req), 32'(exp_req[k]));
      check_output("t2_job_ready", 32'(ifc.job_ready), 32'(exp_jr[k]));
      check_output("t2_bus_valid", 32'(ifc.bus_valid), 32'(exp_bv[k]));
      if (k == 7) ifc.job_valid = 1'b0;
    end

    $display("[TB] stalled 3-beat job");
    ifc.job_valid = 1'b1;
    ifc.job_len   = 4'd2;
    hs_base       = hs_cnt;
    next_cycle();
    ifc.job_valid = 1'b0;
    next_cycle();
    next_cycle();
    check_output("t3_beat0", 32'(ifc.beat_idx), 0);
    next_cycle();
    check_output("t3_beat1", 32'(ifc.beat_idx), 1);
    ifc.bus_ready = 1'b0;
    for (int k = 5; k <= 9; k++) begin
      next_cycle();
      check_output("t3_stall_idx", 32'(ifc.beat_idx), 1);
      check_output("t3_stall_req", 32'(ifc.req), 1);
      check_output("t3_stall_bv", 32'(ifc.bus_valid), 1);
    end
    ifc.bus_ready = 1'b1;
    next_cycle();
    check_output("t3_beat2", 32'(ifc.beat_idx), 2);
    check_output("t3_last", 32'(ifc.bus_last), 1);
    next_cycle();
    check_output("t3_req_drop", 32'(ifc.req), 0);
    check_output("t3_handshakes", 32'(hs_cnt - hs_base), 3);
    next_cycle();
    next_cycle();
    check_output("t3_idle", 32'(ifc.job_ready), 1);

    $display("[TB] starvation");
    arb_en        = 1'b0;
    ifc.job_valid = 1'b1;
    ifc.job_len   = 4'd1;
    for (int k = 1; k <= 70; k++) begin
      next_cycle();
      if (k == 1) ifc.job_valid = 1'b0;
      if (k == 64) check_output("t4_starve_pre", 32'(starve), 0);
      if (k == 65) check_output("t4_starve_set", 32'(starve), 1);
    end
    check_output("t4_req_held", 32'(ifc.req), 1);
    check_output("t4_no_beat", 32'(ifc.bus_valid), 0);
    arb_en = 1'b1;
    next_cycle();
    next_cycle();
    check_output("t4_xfer_bv", 32'(ifc.bus_valid), 1);
    check_output("t4_xfer_starve", 32'(starve), 1);
    next_cycle();
    check_output("t4_last", 32'(ifc.bus_last), 1);
    next_cycle();
    next_cycle();
    next_cycle();
    check_output("t4_idle", 32'(ifc.job_ready), 1);
    check_output("t4_starve_sticky", 32'(starve), 1);

    $display("[TB] grant loss");
    ifc.job_valid = 1'b1;
    ifc.job_len   = 4'd3;
    next_cycle();
    check_output("t5_starve_clr", 32'(starve), 0);
    ifc.job_valid = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    check_output("t5_beat1", 32'(ifc.beat_idx), 1);
    hs_base    = hs_cnt;
    grant_kill = 1'b1;
    #1;
    check_output("t5_bv_lost", 32'(ifc.bus_valid), 0);
    check_output("t5_err_pre", 32'(err_lost), 0);
    next_cycle();
    check_output("t5_err_pulse", 32'(err_lost), 1);
    check_output("t5_req_drop", 32'(ifc.req), 0);
    next_cycle();
    check_output("t5_err_end", 32'(err_lost), 0);
    check_output("t5_idle", 32'(ifc.job_ready), 1);
    check_output("t5_no_hs", 32'(hs_cnt - hs_base), 0);
    grant_kill = 1'b0;

    $display("[TB] reset mid-burst");
    ifc.job_valid = 1'b1;
    ifc.job_len   = 4'd3;
    next_cycle();
    ifc.job_valid = 1'b0;
    repeat (4) next_cycle();
    check_output("t6_beat2", 32'(ifc.beat_idx), 2);
    check_output("t6_bv_pre", 32'(ifc.bus_valid), 1);
    rst_n = 1'b0;
    #1;
    check_output("t6_req", 32'(ifc.req), 0);
    check_output("t6_bv", 32'(ifc.bus_valid), 0);
    check_output("t6_starve", 32'(starve), 0);
    check_output("t6_jr", 32'(ifc.job_ready), 1);
    check_output("t6_idx", 32'(ifc.beat_idx), 0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    check_output("t6_idle", 32'(ifc.job_ready), 1);
    check_output("t6_req_idle", 32'(ifc.req), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
